// File: rtl/rx_word_pkg.sv
// Shared types and defaults for the two-byte word receiver.
package rx_word_pkg;

    localparam int TIMEOUT_CYC_DEF = 1024;

    // IDLE waits for the high byte; WAIT_LOW waits for the low byte.
    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_LOW = 1'b1
    } rx_state_e;

    // Counter width; kept at least one bit so a degenerate TIMEOUT_CYC=1 still elaborates.
    function automatic int cnt_width(input int cyc);
        return (cyc > 1) ? $clog2(cyc) : 1;
    endfunction

endpackage

// File: rtl/rx_timeout_cnt.sv
// Saturating wait counter: clears on clr, counts on en, holds at TIMEOUT_CYC-1.
module rx_timeout_cnt
    import rx_word_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = cnt_width(TIMEOUT_CYC);
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == TERM);

    // Next count: clear wins, otherwise count up until terminal and hold there.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && !expired)
            cnt_d = cnt_q + 1'b1;
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/rx_word_sm.sv
// Assembles 16-bit words from high-then-low byte strobes, with ready/overrun
// handshake and a timeout that discards a stranded high byte.
module rx_word_sm
    import rx_word_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_rdy,
    input  logic [7:0]  rx_byte,
    input  logic        clr_rdy,
    output logic [15:0] rx_data,
    output logic        rdy,
    output logic        overrun,
    output logic        timeout
);

    rx_state_e   state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic [15:0] data_q, data_d;
    logic        rdy_q, rdy_d;
    logic        ovr_q, ovr_d;
    logic        to_q, to_d;
    logic        expired;
    logic        word_done;

    // The counter idles at zero in IDLE, which also clears it on entry to WAIT_LOW.
    rx_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tcnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q == IDLE),
        .en      ((state_q == WAIT_LOW) && !byte_rdy),
        .expired (expired)
    );

    assign word_done = (state_q == WAIT_LOW) && byte_rdy;

    // Next-state and output-register logic; a low byte at terminal count still wins.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        data_d  = data_q;
        rdy_d   = rdy_q;
        ovr_d   = ovr_q;
        to_d    = 1'b0;
        if (clr_rdy) begin
            rdy_d = 1'b0;
            ovr_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (byte_rdy) begin
                    hold_d  = rx_byte;
                    state_d = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (byte_rdy) begin
                    state_d = IDLE;
                end else if (expired) begin
                    state_d = IDLE;
                    to_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (word_done) begin
            data_d = {hold_q, rx_byte};
            rdy_d  = 1'b1;
            // Overrun only when the previous word is still pending and not being acked now.
            ovr_d  = clr_rdy ? 1'b0 : (ovr_q | rdy_q);
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= 8'h00;
            data_q  <= 16'h0000;
            rdy_q   <= 1'b0;
            ovr_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            ovr_q   <= ovr_d;
            to_q    <= to_d;
        end
    end

    assign rx_data = data_q;
    assign rdy     = rdy_q;
    assign overrun = ovr_q;
    assign timeout = to_q;

endmodule
